// File: rtl/xalu_hilo_pkg.sv
// Shared HI/LO unit definitions: op encoding, op width and default busy cycle counts.
package xalu_hilo_pkg;

    localparam int START_SIZE      = 4;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic [START_SIZE-1:0] {
        XALU_NONE  = 4'd0,
        XALU_MULT  = 4'd1,
        XALU_MULTU = 4'd2,
        XALU_DIV   = 4'd3,
        XALU_DIVU  = 4'd4,
        XALU_MTHI  = 4'd5,
        XALU_MTLO  = 4'd6,
        XALU_MFHI  = 4'd7,
        XALU_MFLO  = 4'd8
    } xalu_op_e;

    function automatic logic is_start_op(input logic [START_SIZE-1:0] op);
        return (op >= XALU_MULT) && (op <= XALU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [START_SIZE-1:0] op);
        return (op == XALU_DIV) || (op == XALU_DIVU);
    endfunction

endpackage

// File: rtl/xalu_hilo_if.sv
// E-stage HI/LO bus: op and operands in, Start/Busy handshake and register views out.
interface xalu_hilo_if;
    import xalu_hilo_pkg::*;

    logic [START_SIZE-1:0] Op;
    logic [31:0]           D1;
    logic [31:0]           D2;
    logic                  Cancel;
    logic                  Start;
    logic                  Busy;
    logic [31:0]           Out;
    logic [31:0]           HI;
    logic [31:0]           LO;

    modport master (
        output Op, D1, D2, Cancel,
        input  Start, Busy, Out, HI, LO
    );

    modport slave (
        input  Op, D1, D2, Cancel,
        output Start, Busy, Out, HI, LO
    );

endinterface

// File: rtl/xalu_hilo_calc.sv
// Combinational mult/div result generator: {PH,PL} plus a commit flag (cleared for divide by zero).
// Zero latency; the FSM in the parent latches these at start.
module xalu_hilo_calc
    import xalu_hilo_pkg::*;
(
    input  logic [START_SIZE-1:0] Op,
    input  logic [31:0]           D1,
    input  logic [31:0]           D2,
    output logic [31:0]           PH,
    output logic [31:0]           PL,
    output logic                  commit
);

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [31:0] b_safe;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;

    // Low 64 bits of a sign-extended unsigned product equal the signed product.
    assign sprod  = {{32{D1[31]}}, D1} * {{32{D2[31]}}, D2};
    assign uprod  = {32'd0, D1} * {32'd0, D2};

    // Divisor forced non-zero so the dividers never see 0; commit is dropped instead.
    assign b_safe = (D2 == 32'd0) ? 32'd1 : D2;
    assign a_mag  = D1[31] ? (32'd0 - D1) : D1;
    assign b_mag  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
    assign sq_mag = a_mag / b_mag;
    assign sr_mag = a_mag % b_mag;

    always_comb begin
        PH     = 32'd0;
        PL     = 32'd0;
        commit = 1'b0;
        case (Op)
            XALU_MULT: begin
                PH     = sprod[63:32];
                PL     = sprod[31:0];
                commit = 1'b1;
            end
            XALU_MULTU: begin
                PH     = uprod[63:32];
                PL     = uprod[31:0];
                commit = 1'b1;
            end
            XALU_DIV: begin
                PL     = (D1[31] ^ b_safe[31]) ? (32'd0 - sq_mag) : sq_mag;
                PH     = D1[31] ? (32'd0 - sr_mag) : sr_mag;
                commit = (D2 != 32'd0);
            end
            XALU_DIVU: begin
                PL     = D1 / b_safe;
                PH     = D1 % b_safe;
                commit = (D2 != 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/xalu_hilo.sv
// HI/LO owner: IDLE/CALC FSM with busy counter; results land N cycles after Start, Busy falls the same cycle.
// Start is refused while Busy, so the hazard unit holds HI/LO ops in D.
module xalu_hilo
    import xalu_hilo_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input logic        clk,
    input logic        reset,
    xalu_hilo_if.slave bus
);

    typedef enum logic {IDLE, CALC} state_e;

    state_e      state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_we;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [31:0] calc_ph;
    logic [31:0] calc_pl;
    logic        calc_commit;
    logic        busy;
    logic        start;

    xalu_hilo_calc u_calc (
        .Op     (bus.Op),
        .D1     (bus.D1),
        .D2     (bus.D2),
        .PH     (calc_ph),
        .PL     (calc_pl),
        .commit (calc_commit)
    );

    assign busy  = (state == CALC);
    assign start = is_start_op(bus.Op) & ~bus.Cancel & ~busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_we <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pend_hi <= calc_ph;
                        pend_lo <= calc_pl;
                        pend_we <= calc_commit;
                        cnt     <= is_div_op(bus.Op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        state   <= CALC;
                    end else if (!bus.Cancel) begin
                        if (bus.Op == XALU_MTHI) hi <= bus.D1;
                        if (bus.Op == XALU_MTLO) lo <= bus.D1;
                    end
                end
                CALC: begin
                    // Cancel is deliberately ignored here: the instruction already left E.
                    if (cnt == 4'd1) begin
                        if (pend_we) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Start = start;
    assign bus.Busy  = busy;
    assign bus.HI    = hi;
    assign bus.LO    = lo;
    assign bus.Out   = (bus.Op == XALU_MFHI) ? hi :
                       (bus.Op == XALU_MFLO) ? lo : 32'd0;

endmodule
